// File: rtl/xfiles_rocc_driver.sv
// RoCC initiator for an X-Files/DANA arbiter port: host op FIFO, instruction encode, issue and response return.
// Optional response watchdog is built when XFILES_DRIVER_TIMEOUT_EN is defined.
module xfiles_rocc_driver #(
  parameter int         FIFO_DEPTH      = 4,
  parameter int         MAX_OUTSTANDING = 4,
  parameter logic [6:0] OPCODE          = 7'h0B,
  parameter int         TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [63:0] rsp_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_bits_inst_funct,
  output logic [4:0]  cmd_bits_inst_rs2,
  output logic [4:0]  cmd_bits_inst_rs1,
  output logic        cmd_bits_inst_xd,
  output logic        cmd_bits_inst_xs1,
  output logic        cmd_bits_inst_xs2,
  output logic [4:0]  cmd_bits_inst_rd,
  output logic [6:0]  cmd_bits_inst_opcode,
  output logic [63:0] cmd_bits_rs1,
  output logic [63:0] cmd_bits_rs2,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [4:0]  resp_bits_rd,
  input  logic [63:0] resp_bits_data,
  input  logic        busy,
  input  logic        interrupt,
  input  logic        clear_err,
  output logic [2:0]  err,
  output logic [3:0]  outstanding
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rd;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

  state_t      state, state_nxt;
  req_t        mem [FIFO_DEPTH];
  req_t        head;
  logic [AW:0] wptr, rptr;
  logic        fifo_full, fifo_empty, push, load;
  logic        head_xd, cmd_hs, resp_hs, resp_ok, timeout_hit;
  logic [6:0]  head_funct;
  logic [2:0]  err_set;
  logic        err_any;
  logic        unused;

  assign unused = busy;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign head       = mem[rptr[AW-1:0]];
  assign head_xd    = (head.op != 2'd0);

  always_comb begin
    head_funct = 7'd0;
    case (head.op)
      2'd0: head_funct = 7'd4;
      2'd1: head_funct = 7'd1;
      2'd2: head_funct = 7'd0;
      2'd3: head_funct = 7'd2;
      default: head_funct = 7'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{op: req_op, rs1: req_rs1, rs2: req_rs2, rd: req_rd};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
    end
  end

  assign cmd_valid  = (state == ISSUE);
  assign cmd_hs     = cmd_valid && cmd_ready;
  assign resp_ready = !rsp_valid || rsp_ready;
  assign resp_hs    = resp_valid && resp_ready;
  assign resp_ok    = resp_hs && (outstanding != 4'd0);

`ifdef XFILES_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    to_cnt <= '0;
    else if (resp_hs || outstanding == 4'd0)     to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))      to_cnt <= to_cnt + 1'b1;
  end
  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // New errors are seen combinationally so nothing issues in the cycle they appear.
  assign err_set = {timeout_hit, interrupt, resp_hs && (outstanding == 4'd0)};
  assign err_any = (|err) || (|err_set);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:
        if (err_any) state_nxt = HALT;
        else if (!fifo_empty && (!head_xd || outstanding < 4'(MAX_OUTSTANDING))) begin
          state_nxt = ISSUE;
          load      = 1'b1;
        end
      ISSUE: if (cmd_ready) state_nxt = err_any ? HALT : IDLE;
      HALT:  if (clear_err && !(|err_set)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      err                  <= '0;
      outstanding          <= '0;
      cmd_bits_inst_funct  <= '0;
      cmd_bits_inst_rs2    <= '0;
      cmd_bits_inst_rs1    <= '0;
      cmd_bits_inst_xd     <= 1'b0;
      cmd_bits_inst_xs1    <= 1'b0;
      cmd_bits_inst_xs2    <= 1'b0;
      cmd_bits_inst_rd     <= '0;
      cmd_bits_inst_opcode <= '0;
      cmd_bits_rs1         <= '0;
      cmd_bits_rs2         <= '0;
      rsp_valid            <= 1'b0;
      rsp_rd               <= '0;
      rsp_data             <= '0;
    end else begin
      state <= state_nxt;
      err   <= clear_err ? err_set : (err | err_set);
      if (load) begin
        cmd_bits_inst_funct  <= head_funct;
        cmd_bits_inst_rs2    <= 5'd2;
        cmd_bits_inst_rs1    <= 5'd1;
        cmd_bits_inst_xd     <= head_xd;
        cmd_bits_inst_xs1    <= 1'b1;
        cmd_bits_inst_xs2    <= 1'b1;
        cmd_bits_inst_rd     <= head.rd;
        cmd_bits_inst_opcode <= OPCODE;
        cmd_bits_rs1         <= head.rs1;
        cmd_bits_rs2         <= head.rs2;
      end
      case ({cmd_hs && cmd_bits_inst_xd, resp_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      // Unexpected responses are consumed but never reach the host.
      if (resp_ok) begin
        rsp_valid <= 1'b1;
        rsp_rd    <= resp_bits_rd;
        rsp_data  <= resp_bits_data;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule
